mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency MainMemory between two requesters: the IF_stage instruction fetch port (IF) and the MEM_stage data port (DM).
- Drives the memory's FETCH_ADDRESS and packed EDIT_SERIAL inputs.
- Sequences each access over MEM_LATENCY cycles, returns read data with a one-cycle ack, and raises a pipeline stall while any request is outstanding.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arb_perf_cnt.sv | 34 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant encodings and serial-width helper for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic {GNT_IF = 1'b0, GNT_DM = 1'b1} gnt_e;
  localparam int SERIAL_W = 1 + 32 + 32;
  function automatic int serial_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction
endpackage

// File: rtl/mem_arb_perf_cnt.sv
// mem_arb_perf_cnt: free-running IF grant, DM grant and stall-cycle counters
module mem_arb_perf_cnt (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        if_grant,
  input  logic        dm_grant,
  input  logic        stall,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_dm_grants,
  output logic [31:0] perf_stall_cycles
);
  logic [31:0] if_cnt_q, if_cnt_d, dm_cnt_q, dm_cnt_d, stall_cnt_q, stall_cnt_d;
  // bump each counter on its event, wrapping naturally
  always_comb begin
    if_cnt_d = if_cnt_q + {31'd0, if_grant};
    dm_cnt_d = dm_cnt_q + {31'd0, dm_grant};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end
  // counter registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      if_cnt_q <= '0;
      dm_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if_cnt_q <= if_cnt_d;
      dm_cnt_q <= dm_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign perf_if_grants = if_cnt_q;
  assign perf_dm_grants = dm_cnt_q;
  assign perf_stall_cycles = stall_cnt_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and DM ports; MEM_ARB_PERF_CNT_EN adds perf counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 3,
  parameter int MAX_DM_RUN = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       if_req,
  input  logic [AW-1:0]              if_addr,
  output logic [DW-1:0]              if_rdata,
  output logic                       if_ack,
  input  logic                       dm_req,
  input  logic                       dm_we,
  input  logic [AW-1:0]              dm_addr,
  input  logic [DW-1:0]              dm_wdata,
  output logic [DW-1:0]              dm_rdata,
  output logic                       dm_ack,
  output logic [AW-1:0]              mem_fetch_addr,
  output logic [serial_w(AW,DW)-1:0] mem_edit_serial,
  input  logic [DW-1:0]              mem_rdata,
  output logic                       pipe_stall
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_if_grants,
  output logic [31:0]                perf_dm_grants,
  output logic [31:0]                perf_stall_cycles
`endif
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  localparam int RW = MAX_DM_RUN > 0 ? $clog2(MAX_DM_RUN + 1) : 1;
  state_e state_q, state_d;
  gnt_e gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic we_q, we_d, if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic if_elig, dm_elig, dm_wins, grant, last;
  // a requester still holding req during its own ack cycle must not be granted again
  assign if_elig = if_req & ~if_ack_q;
  assign dm_elig = dm_req & ~dm_ack_q;
  assign dm_wins = dm_elig & ~(if_elig & (run_q == RW'(MAX_DM_RUN)));
  assign grant = (state_q == IDLE) & (if_elig | dm_elig);
  assign last = (state_q == BUSY) & (cnt_q == '0);
  // memory sees the latched access only while busy; the write enable fires once, in the final cycle
  assign mem_fetch_addr = state_q == BUSY ? addr_q : '0;
  assign mem_edit_serial = state_q == BUSY ? {we_q & last, addr_q, wdata_q} : '0;
  assign if_ack = if_ack_q;
  assign dm_ack = dm_ack_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign pipe_stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);
  // next-state: grant from IDLE, count down while BUSY, capture data and ack on the last cycle
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    run_d = run_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d = 1'b0;
    dm_ack_d = 1'b0;
    if (grant) begin
      state_d = BUSY;
      gnt_d = dm_wins ? GNT_DM : GNT_IF;
      cnt_d = CW'(MEM_LATENCY - 1);
      addr_d = dm_wins ? dm_addr : if_addr;
      we_d = dm_wins & dm_we;
      wdata_d = dm_wins ? dm_wdata : '0;
      run_d = (dm_wins & if_req) ? (run_q == RW'(MAX_DM_RUN) ? run_q : run_q + 1'b1) : '0;
    end
    if (state_q == BUSY) begin
      cnt_d = last ? cnt_q : cnt_q - 1'b1;
      if (last) begin
        state_d = IDLE;
        if_ack_d = gnt_q == GNT_IF;
        dm_ack_d = gnt_q == GNT_DM;
        if_rdata_d = gnt_q == GNT_IF ? mem_rdata : if_rdata_q;
        dm_rdata_d = gnt_q == GNT_DM ? mem_rdata : dm_rdata_q;
      end
    end
  end
  // state registers; async reset aborts any access in flight
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      gnt_q <= GNT_IF;
      cnt_q <= '0;
      run_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q <= if_ack_d;
      dm_ack_q <= dm_ack_d;
    end
  end
`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf_cnt u_perf (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .if_grant(grant & ~dm_wins),
    .dm_grant(grant & dm_wins),
    .stall(pipe_stall),
    .perf_if_grants(perf_if_grants),
    .perf_dm_grants(perf_dm_grants),
    .perf_stall_cycles(perf_stall_cycles)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios checked against a cycle-indexed transaction model
module tb_mem_port_arbiter;
  localparam int L = 3;
  localparam int MAXR = 4;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata, mem_fetch_addr, mem_rdata;
  logic if_ack, dm_ack, pipe_stall;
  logic [64:0] mem_edit_serial;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_dm_grants, perf_stall_cycles;
`endif
  int vectors = 0;
  int errors = 0;
  int we_pulses = 0;

  mem_port_arbiter #(.MEM_LATENCY(L), .MAX_DM_RUN(MAXR), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_fetch_addr(mem_fetch_addr), .mem_edit_serial(mem_edit_serial),
    .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'hDEADBEEF : i == 32 ? 32'hAAAA5555 : (32'hC0DE0000 | 32'(i));
  endfunction

  // environment memory: combinational read, write on the edge closing the we cycle
  logic [31:0] bmem [256];
  bit binit = 0;
  assign mem_rdata = bmem[mem_fetch_addr[9:2]];
  always @(posedge CLK) begin
    if (!binit) begin
      for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
      binit <= 1;
    end else if (mem_edit_serial[64]) bmem[mem_edit_serial[41:34]] <= mem_edit_serial[31:0];
  end

  // transaction model: a grant decided in cycle g occupies cycles g+1..g+L and acks in g+L+1
  logic [31:0] rmem [256];
  bit rinit = 0;
  int cyc = 0;
  bit job_v = 0;
  int job_g = 0;
  logic job_dm = 0, job_we = 0;
  logic [31:0] job_addr = 0, job_wdata = 0, ack_data = 0;
  int ack_c = -1;
  logic ack_dm = 0;
  int run = 0;
  function automatic bit m_busy();
    return job_v && cyc > job_g && cyc <= job_g + L;
  endfunction
  function automatic bit m_if_ack();
    return ack_c == cyc && !ack_dm;
  endfunction
  function automatic bit m_dm_ack();
    return ack_c == cyc && ack_dm;
  endfunction
  function automatic logic [64:0] m_serial();
    return m_busy() ? {job_we && cyc == job_g + L, job_addr, job_wdata} : 65'h0;
  endfunction
  always @(posedge CLK or negedge RESET_N) begin
    if (!rinit) begin
      for (int i = 0; i < 256; i++) rmem[i] <= init_word(i);
      rinit <= 1;
    end
    if (!RESET_N) begin
      job_v <= 0;
      ack_c <= -1;
      run <= 0;
    end else begin
      cyc <= cyc + 1;
      if (job_v && cyc == job_g + L) begin
        ack_c <= cyc + 1;
        ack_dm <= job_dm;
        ack_data <= rmem[job_addr[9:2]];
        if (job_we) rmem[job_addr[9:2]] <= job_wdata;
        job_v <= 0;
      end else if (!m_busy() && ((if_req && !m_if_ack()) || (dm_req && !m_dm_ack()))) begin
        job_v <= 1;
        job_g <= cyc;
        if (dm_req && !m_dm_ack() && !(if_req && !m_if_ack() && run == MAXR)) begin
          job_dm <= 1;
          job_we <= dm_we;
          job_addr <= dm_addr;
          job_wdata <= dm_wdata;
          run <= if_req ? (run < MAXR ? run + 1 : run) : 0;
        end else begin
          job_dm <= 0;
          job_we <= 0;
          job_addr <= if_addr;
          job_wdata <= 0;
          run <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    chk("mem_fetch_addr", mem_fetch_addr, m_busy() ? job_addr : 32'h0);
    chk("mem_edit_serial", mem_edit_serial, m_serial());
    chk("if_ack", if_ack, m_if_ack());
    chk("dm_ack", dm_ack, m_dm_ack());
    if (m_if_ack()) chk("if_rdata", if_rdata, ack_data);
    if (m_dm_ack()) chk("dm_rdata", dm_rdata, ack_data);
    chk("pipe_stall", pipe_stall, (if_req && !m_if_ack()) || (dm_req && !m_dm_ack()));
    chk("ack_exclusive", if_ack & dm_ack, 1'b0);
    if (mem_edit_serial[64]) we_pulses <= we_pulses + 1;
  end

  task automatic access(input bit dm, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int k, output logic [31:0] r);
    if (dm) begin
      dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = d;
    end else begin
      if_req = 1; if_addr = a;
    end
    k = -1;
    r = '0;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      @(posedge CLK); #1;
      if (dm ? dm_ack : if_ack) begin
        k = i;
        r = dm ? dm_rdata : if_rdata;
      end
    end
    if (dm) dm_req = 0; else if_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, kd, ki, wp, nd, first, second, ifacks, acks_in_rst;
    logic [31:0] r;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] p_if, p_dm, p_st;
`endif
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset fetch_addr", mem_fetch_addr, 32'h0);
    chk("reset edit_serial", mem_edit_serial, 65'h0);
    chk("reset if_ack", if_ack, 1'b0);
    chk("reset dm_ack", dm_ack, 1'b0);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset dm_rdata", dm_rdata, 32'h0);
    chk("reset pipe_stall", pipe_stall, 1'b0);
    RESET_N = 1;
    @(posedge CLK); #1;

    access(0, 0, 32'h10, 0, k, r);
    chk("if read ack cycle", k, 4);
    chk("if read data", r, 32'hDEADBEEF);
    @(posedge CLK); #1;

    wp = we_pulses;
    access(1, 1, 32'h40, 32'h12345678, k, r);
    chk("dm store ack cycle", k, 4);
    chk("dm store we pulses", we_pulses - wp, 1);
    access(1, 0, 32'h40, 0, k, r);
    chk("dm load after store", r, 32'h12345678);
    @(posedge CLK); #1;

`ifdef MEM_ARB_PERF_CNT_EN
    p_if = perf_if_grants; p_dm = perf_dm_grants; p_st = perf_stall_cycles;
`endif
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    kd = -1; ki = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLK); #1;
      if (kd > 0 && i == kd + 1) dm_req = 0;
      if (ki > 0 && i == ki + 1) if_req = 0;
      if (dm_ack && kd < 0) kd = i;
      if (if_ack && ki < 0) ki = i;
    end
    if_req = 0; dm_req = 0;
    chk("both req dm ack cycle", kd, 4);
    chk("both req if ack cycle", ki, 8);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_if_grants", perf_if_grants - p_if, 1);
    chk("perf_dm_grants", perf_dm_grants - p_dm, 1);
    chk("perf_stall_cycles", perf_stall_cycles - p_st, 8);
`endif

    dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h11112222;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2 RESET_N = 0; dm_req = 0;
    #1;
    chk("mid reset fetch_addr", mem_fetch_addr, 32'h0);
    chk("mid reset edit_serial", mem_edit_serial, 65'h0);
    acks_in_rst = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      acks_in_rst += int'(dm_ack) + int'(if_ack);
    end
    RESET_N = 1;
    repeat (3) begin
      @(posedge CLK); #1;
      acks_in_rst += int'(dm_ack) + int'(if_ack);
    end
    chk("aborted store acks", acks_in_rst, 0);
    access(1, 0, 32'h80, 0, k, r);
    chk("aborted store word unchanged", r, 32'hAAAA5555);
    @(posedge CLK); #1;

    dm_req = 1; dm_we = 0; dm_addr = 32'h10; if_addr = 32'h40; if_req = 1;
    nd = 0; ifacks = 0; first = -1; second = -1;
    for (int i = 0; i < 80 && ifacks < 2; i++) begin
      @(posedge CLK); #1;
      if (dm_ack) nd++;
      if (if_ack) begin
        ifacks++;
        if (ifacks == 1) first = nd; else second = nd;
        nd = 0;
      end
      if_req = !dm_ack && !if_ack && ifacks < 2;
      if (ifacks == 2) dm_req = 0;
    end
    if_req = 0; dm_req = 0;
    chk("dm acks before forced if", first, 4);
    chk("dm acks between forced ifs", second, 5);

    repeat (6) @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
